// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers h/v position from incoming hsync/vsync and
// blanks the pixel stream until both sync axes have locked.
module vga_sync_decoder #(
    parameter int H_DISPLAY  = 640,
    parameter int H_L_BORDER = 48,
    parameter int H_R_BORDER = 16,
    parameter int H_RETRACE  = 96,
    parameter int V_DISPLAY  = 480,
    parameter int V_T_BORDER = 10,
    parameter int V_B_BORDER = 33,
    parameter int V_RETRACE  = 2,
    parameter int H_LOCK     = 4,
    parameter int V_LOCK     = 2,
    parameter int TIMEOUT    = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic [11:0] rgb_out,
    output logic [9:0]  h,
    output logic [9:0]  v,
    output logic        vidstate,
    output logic        locked,
    output logic        frame_start
);
    localparam int H_MAX    = H_DISPLAY + H_L_BORDER + H_R_BORDER + H_RETRACE - 1;
    localparam int HS_START = H_DISPLAY + H_R_BORDER;
    localparam int V_MAX    = V_DISPLAY + V_T_BORDER + V_B_BORDER + V_RETRACE - 1;
    localparam int VS_START = V_DISPLAY + V_B_BORDER;
    localparam int HW       = $clog2(H_LOCK + 1);
    localparam int VW       = $clog2(V_LOCK + 1);
    localparam int TW       = $clog2(TIMEOUT + 1);

    logic          hs_r, vs_r, h_lock, v_lock;
    logic [11:0]   rgb_r;
    logic [HW-1:0] hm, hm_inc;
    logic [VW-1:0] vm, vm_inc;
    logic [TW-1:0] tcnt;
    logic [9:0]    h_pred, v_pred;
    logic          hs_edge, vs_edge, h_match, v_match, timeout;

    always_comb begin
        hs_edge     = hsync & ~hs_r;
        vs_edge     = vsync & ~vs_r;
        h_pred      = (h == 10'(H_MAX)) ? 10'd0 : h + 10'd1;
        v_pred      = (h != 10'(H_MAX)) ? v : (v == 10'(V_MAX)) ? 10'd0 : v + 10'd1;
        h_match     = h_pred == 10'(HS_START);
        v_match     = v_pred == 10'(VS_START);
        hm_inc      = (hm == HW'(H_LOCK)) ? hm : hm + HW'(1);
        vm_inc      = (vm == VW'(V_LOCK)) ? vm : vm + VW'(1);
        timeout     = tcnt == TW'(TIMEOUT);
        vidstate    = (h < 10'(H_DISPLAY)) && (v < 10'(V_DISPLAY));
        rgb_out     = (vidstate && locked) ? rgb_r : 12'h000;
        frame_start = (h == 10'd0) && (v == 10'd0) && locked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r   <= 1'b0;
            vs_r   <= 1'b0;
            rgb_r  <= '0;
            h      <= '0;
            v      <= '0;
            hm     <= '0;
            vm     <= '0;
            tcnt   <= '0;
            h_lock <= 1'b0;
            v_lock <= 1'b0;
            locked <= 1'b0;
        end else begin
            hs_r   <= hsync;
            vs_r   <= vsync;
            rgb_r  <= rgb_in;
            h      <= hs_edge ? 10'(HS_START) : h_pred;
            v      <= vs_edge ? 10'(VS_START) : v_pred;
            locked <= h_lock & v_lock;
            tcnt   <= hs_edge ? '0 : timeout ? tcnt : tcnt + TW'(1);
            if (hs_edge) begin
                hm     <= h_match ? hm_inc : HW'(1);
                h_lock <= h_match & (h_lock | (hm_inc == HW'(H_LOCK)));
            end
            if (vs_edge) begin
                vm     <= v_match ? vm_inc : VW'(1);
                v_lock <= v_match & (v_lock | (vm_inc == VW'(V_LOCK)));
            end
            // losing hsync for too long invalidates everything learned so far
            if (timeout && !hs_edge) begin
                hm     <= '0;
                vm     <= '0;
                h_lock <= 1'b0;
                v_lock <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench driving a scaled-down ideal VGA stream.
module tb_vga_sync_decoder;
    localparam int HD = 16, HL = 4, HR = 2, HRT = 6;
    localparam int VD = 8, VTB = 1, VBB = 2, VR = 2;
    localparam int TO = 60;
    localparam int HT = HD + HL + HR + HRT;
    localparam int HS = HD + HR;
    localparam int VT = VD + VTB + VBB + VR;
    localparam int VS = VD + VBB;
    localparam int F  = HT * VT;

    logic        clk = 1'b0, rst = 1'b1, hsync = 1'b0, vsync = 1'b0;
    logic [11:0] rgb_in = '0, rgb_out;
    logic [9:0]  h, v;
    logic        vidstate, locked, frame_start;

    typedef struct {
        logic        chk;
        logic [34:0] exp;
    } ent_t;

    ent_t sb[$];
    int   passed = 0, total = 0;
    int   gh, gv, hgood, fs_cnt;
    logic prev_hs, lk, bad, chk_on, fff;

    localparam logic [34:0] RST_EXP = {1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 12'h000};

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_DISPLAY(HD), .H_L_BORDER(HL), .H_R_BORDER(HR), .H_RETRACE(HRT),
        .V_DISPLAY(VD), .V_T_BORDER(VTB), .V_B_BORDER(VBB), .V_RETRACE(VR),
        .H_LOCK(4), .V_LOCK(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .rgb_out(rgb_out), .h(h), .v(v), .vidstate(vidstate),
        .locked(locked), .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [34:0] obs();
        return {locked, frame_start, vidstate, h, v, rgb_out};
    endfunction

    // one input cycle of the ideal generator; the expected DUT view of it
    // appears one cycle later, so it is queued here and checked on the next step
    task automatic drive(input logic shorten);
        logic        hs_now, vs_now, vid, hs_rise;
        logic [11:0] pix;
        ent_t        e;
        hs_now  = gh >= HS && gh < HS + HRT;
        vs_now  = gv >= VS && gv < VS + VR;
        hs_rise = hs_now && !prev_hs;
        pix     = fff ? 12'hFFF : 12'(gv * 256 + gh + 1);
        vid     = gh < HD && gv < VD;
        hsync   = hs_now;
        vsync   = vs_now;
        rgb_in  = pix;
        e.chk   = chk_on && !(bad && !hs_rise);
        e.exp   = {lk, lk && gh == 0 && gv == 0, vid, 10'(gh), 10'(gv), (lk && vid) ? pix : 12'h000};
        sb.push_back(e);
        if (hs_rise) begin
            hgood = bad ? 1 : (hgood < 4 ? hgood + 1 : 4);
            bad   = 1'b0;
            lk    = hgood >= 4;
        end
        prev_hs = hs_now;
        if (shorten) bad = 1'b1;
        if (gh == HT - 1 || shorten) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else gh = gh + 1;
    endtask

    task automatic step(input logic shorten);
        ent_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (frame_start) fs_cnt++;
            if (e.chk) check("stream", obs(), e.exp);
        end
        drive(shorten);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic gen_restart();
        gh = 0; gv = 0; prev_hs = 1'b0; hgood = 0; lk = 1'b0; bad = 1'b0;
    endtask

    task automatic assume_locked();
        hgood = 4; lk = 1'b1; chk_on = 1'b1;
    endtask

    initial begin
        gen_restart();
        chk_on = 1'b0; fff = 1'b0; fs_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_state", obs(), RST_EXP);
        rst = 1'b0;
        run(F);
        check("no_lock_one_frame", {34'd0, locked}, 35'd0);
        run(F);
        assume_locked();
        fs_cnt = 0;
        run(F);
        check("fs_per_frame", 35'(fs_cnt), 35'd1);
        fff = 1'b1;
        fs_cnt = 0;
        run(F);
        check("fs_per_frame_fff", 35'(fs_cnt), 35'd1);
        fff = 1'b0;
        for (int i = 0; i < F && !(gv == 2 && gh == HT - 2); i++) run(1);
        step(1'b1);
        run(8 * HT);
        check("relocked_after_short", {34'd0, locked}, 35'd1);
        chk_on = 1'b0;
        repeat (2 * TO) begin
            step(1'b0);
            hsync = 1'b0; vsync = 1'b0; rgb_in = 12'hFFF;
            void'(sb.pop_back());
        end
        @(negedge clk);
        sb.delete();
        check("timeout_drop", {locked, rgb_out}, 13'd0);
        gen_restart();
        run(2 * F);
        assume_locked();
        run(F);
        for (int i = 0; i < F && !(gv == 5 && gh == 10); i++) run(1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", obs(), RST_EXP);
        sb.delete();
        chk_on = 1'b0; hgood = 0; lk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_held", obs(), RST_EXP);
        rst = 1'b0;
        run(2 * F + HT);
        assume_locked();
        run(F);
        check("relock_after_reset", {34'd0, locked}, 35'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
